systolic_mac4: RTL
==================

# systolic_mac4

Systolic processing element that consumes the 8-bit products of a 4x4 unsigned multiplier and reduces them into dot-product results. Each cycle it accepts one 4-bit operand pair, forwards both operands unchanged to its east and south neighbours one cycle later, and adds their product into a saturating accumulator. After `LEN` valid terms it publishes the sum on a ready/valid result port. One instance sits at every node of the systolic array, with the existing 4x4 multiplier instantiated inside as its combinational product stage.

## Interface
- `ACC_W`, 16, accumulator and result width in bits; legal range ≥ 8.
- `LEN`, 4, number of valid terms per dot product; legal range ≥ 1.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  reset; asynchronous and active-high.
- `a_in`  in  4  west operand, unsigned.
- `b_in`  in  4  north operand, unsigned.
- `in_valid`  in  1  `a_in`/`b_in` form a valid term this cycle.
- `clear`  in  1  synchronous abort of the partial sum in progress.
- `a_out`  out  4  registered copy of `a_in`, to the east neighbour.
- `b_out`  out  4  registered copy of `b_in`, to the south neighbour.
- `out_valid`  out  1  registered copy of `in_valid`.
- `res_data`  out  ACC_W  completed dot product.
- `res_sat`  out  1  `res_data` was clamped by saturation.
- `res_valid`  out  1  the result register holds an unconsumed result.
- `res_ready`  in  1  the consumer takes the result this cycle.
- `overrun`  out  1  sticky flag: a result was overwritten before it was consumed.

## Operation
- Product: `p = a_in * b_in`, 8 bits from the 4x4 multiplier, zero-extended to `ACC_W`.
- Forwarding: `a_out`, `b_out` and `out_valid` register their inputs every cycle, independent of `in_valid`, `clear` and result backpressure. The block never stalls its inputs.
- Term counter `cnt` runs 0..LEN-1. The accumulator FSM has two states:
  - IDLE (`cnt == 0`, no partial sum).
  - RUN (partial sum held).
- Sum rule: `sum = (state == IDLE ? 0 : acc) + p`.
  - If the true sum exceeds `2^ACC_W - 1`, `sum` clamps to `2^ACC_W - 1` and the per-result saturation bit is set.
  - The saturation bit clears at the start of each new dot product.
- On `in_valid` with `cnt < LEN-1`: `acc <= sum`, `cnt` increments, state goes to RUN.
- On `in_valid` with `cnt == LEN-1` (final term):
  - `res_data <= sum`.
  - `res_sat <=` the saturation bit including this term.
  - `res_valid <= 1`.
  - `cnt <= 0` and state goes to IDLE.
  - With `LEN = 1`, every valid term is a final term.
- Result handshake:
  - A transfer occurs on any cycle with `res_valid && res_ready`.
  - `res_valid` falls after a transfer unless a new result loads in the same cycle; in that case `res_valid` stays 1 with the new data and `overrun` is not set.
  - If a new result loads while `res_valid == 1` and `res_ready == 0`, the old result is lost, the new one replaces it, and `overrun` is set to 1.
  - `overrun` is cleared only by `rst`.
- `clear`:
  - Drops the partial sum: `cnt <= 0`, state goes to IDLE, saturation bit cleared.
  - Does not affect the result register or `overrun`.
  - With `clear` and `in_valid` in the same cycle, the current term becomes term 0 of a new dot product, so `acc <= p` and `cnt <= 1`. When `LEN = 1`, it produces a result immediately.
- `in_valid == 0`: accumulator, counter and state hold.

## Timing
- Reset: all outputs read 0 while `rst` is high (`a_out`, `b_out`, `out_valid`, `res_data`, `res_sat`, `res_valid`, `overrun`), plus `acc`, `cnt` and state (IDLE).
- Asserting `rst` mid-dot-product or mid-handshake discards everything immediately, without waiting for a clock edge.
- Forwarding latency: 1 cycle.
- Result latency: final term presented in cycle t → `res_valid`/`res_data` visible after edge t+1.
- Throughput: one term per cycle sustained. Back-to-back dot products need no bubble.
- The product path is combinational from `a_in`/`b_in` into the accumulator adder. There are no registers inside the multiplier.

## Test plan
- Reset, then 4 valid terms (a,b) = (3,5), (15,15), (0,9), (2,7), `res_ready = 1` → `out_valid` follows `in_valid` one cycle later; `res_valid` pulses one cycle with `res_data = 15 + 225 + 0 + 14 = 254`; `res_sat = 0`.
- Continuous terms all (15,15) across 3 dot products, `res_ready = 1`, `ACC_W = 16` → three results of 900, one every 4 cycles; no bubble; `overrun = 0`.
- `ACC_W = 9`, four terms of (15,15) → `res_data = 511`, `res_sat = 1`. The next dot product of (1,1) ×4 gives 4 with `res_sat = 0`.
- Two full dot products with `res_ready = 0` → second result (e.g. 4) replaces the first (254); `overrun = 1` and stays 1. Raising `res_ready` transfers once, then `res_valid = 0`.
- `clear` asserted with `in_valid` after 2 terms (3,5),(3,5), current term (2,2), then 3 more (1,1) → `res_data = 4 + 3 = 7`. A separate `clear` without `in_valid` mid-sum leaves a pending `res_valid`/`res_data` unchanged.
- `rst` pulsed asynchronously (between edges) after 2 terms with a result pending → all outputs 0 immediately; a following 4-term sequence (1,2)×4 yields 8.

Source files
------------

// File: rtl/systolic_mac4.sv
// Systolic processing element: forwards 4-bit operands east/south and reduces
// their products into saturating LEN-term dot products on a ready/valid port.

module mult4x4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [7:0] p
);
  assign p = {4'b0000, a} * {4'b0000, b};
endmodule

module systolic_mac4 #(
  parameter int ACC_W = 16,
  parameter int LEN   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       a_in,
  input  logic [3:0]       b_in,
  input  logic             in_valid,
  input  logic             clear,
  output logic [3:0]       a_out,
  output logic [3:0]       b_out,
  output logic             out_valid,
  output logic [ACC_W-1:0] res_data,
  output logic             res_sat,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             overrun
);
  localparam int CNT_W = (LEN > 1) ? $clog2(LEN) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(LEN - 1);

  typedef enum logic [0:0] {IDLE = 1'b0, RUN = 1'b1} state_t;

  // Carry out of the widened add means the true sum exceeded 2^ACC_W-1.
  // Returns {saturated, clamped_sum}.
  function automatic logic [ACC_W:0] sat_add(input logic [ACC_W-1:0] base,
                                             input logic [7:0] prod);
    logic [ACC_W:0] full;
    full = {1'b0, base} + {{(ACC_W - 7){1'b0}}, prod};
    if (full[ACC_W]) sat_add = {1'b1, {ACC_W{1'b1}}};
    else             sat_add = full;
  endfunction

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [ACC_W-1:0] acc, acc_nxt;
  logic             sat_run, sat_nxt;

  logic [7:0]       prod_p0;
  logic             first_p0;
  logic [CNT_W-1:0] cnt_eff_p0;
  logic [ACC_W-1:0] base_p0;
  logic [ACC_W-1:0] sum_p0;
  logic             sat_add_p0;
  logic             sat_in_p0;
  logic             last_p0;

  // Stage p0: combinational product and saturating accumulate
  mult4x4 u_mult (
    .a (a_in),
    .b (b_in),
    .p (prod_p0)
  );

  // clear folds into the current term: it restarts the dot product at term 0
  always_comb begin
    first_p0   = clear || (state == IDLE);
    cnt_eff_p0 = clear ? '0 : cnt;
    base_p0    = first_p0 ? '0 : acc;
    sat_in_p0  = first_p0 ? 1'b0 : sat_run;
    {sat_add_p0, sum_p0} = sat_add(base_p0, prod_p0);
    last_p0    = in_valid && (cnt_eff_p0 == LAST);
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    acc_nxt   = acc;
    sat_nxt   = sat_run;
    if (in_valid) begin
      if (last_p0) begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
        sat_nxt   = 1'b0;
      end else begin
        state_nxt = RUN;
        cnt_nxt   = cnt_eff_p0 + CNT_W'(1);
        acc_nxt   = sum_p0;
        sat_nxt   = sat_in_p0 | sat_add_p0;
      end
    end else if (clear) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
      sat_nxt   = 1'b0;
    end
  end

  // Stage p1: accumulator state, forwarding registers and result register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      acc       <= '0;
      sat_run   <= 1'b0;
      a_out     <= '0;
      b_out     <= '0;
      out_valid <= 1'b0;
      res_data  <= '0;
      res_sat   <= 1'b0;
      res_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      acc       <= acc_nxt;
      sat_run   <= sat_nxt;
      a_out     <= a_in;
      b_out     <= b_in;
      out_valid <= in_valid;
      if (last_p0) begin
        res_data  <= sum_p0;
        res_sat   <= sat_in_p0 | sat_add_p0;
        res_valid <= 1'b1;
        if (res_valid && !res_ready) overrun <= 1'b1;
      end else if (res_valid && res_ready) begin
        res_valid <= 1'b0;
      end
    end
  end
endmodule
